// File: rtl/sw_cond_pkg.sv
// -----------------------------------------------------------------------------
// sw_cond_pkg
// Shared constants for the switch-conditioning stage in front of the lab1
// switch-to-LED logic.
//   SW_WIDTH_DEFAULT     : default number of conditioned switch bits
//   DEBOUNCE_20MS_100MHZ : 20 ms qualification window at a 100 MHz clk
//   DEBOUNCE_SIM         : short qualification window for simulation
//   cnt_width()          : stability-counter width for a given window length
// -----------------------------------------------------------------------------
package sw_cond_pkg;

    localparam int SW_WIDTH_DEFAULT     = 4;
    localparam int DEBOUNCE_20MS_100MHZ = 2000000;
    localparam int DEBOUNCE_SIM         = 4;

    // The counter only has to reach cycles-1, so clog2(cycles) bits suffice.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// -----------------------------------------------------------------------------
// sw_debounce_bit
// One switch bit: 2-flop synchroniser, stability counter, accepted-level flop
// and (optionally) registered rise/fall pulses.
// Optional feature macro: SW_EDGE_PULSE_EN (adds o_rise/o_fall/o_accept and
// their registers; absent otherwise).
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   i_sw_raw  : raw switch level, asynchronous to clk
//   o_stable  : debounced level
//   o_rise    : one-cycle pulse on accepted 0->1      (SW_EDGE_PULSE_EN)
//   o_fall    : one-cycle pulse on accepted 1->0      (SW_EDGE_PULSE_EN)
//   o_accept  : combinational, high on the accepting edge's cycle
//               (lets the parent register its OR alongside the pulses)
// -----------------------------------------------------------------------------
module sw_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sw_raw,
    output logic o_stable
`ifdef SW_EDGE_PULSE_EN
    ,
    output logic o_rise,
    output logic o_fall,
    output logic o_accept
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;
    logic             w_mismatch;
    logic             w_terminal;
    logic             w_accept;

    assign w_mismatch = r_s2 ^ r_stable;
    assign w_terminal = (r_cnt == CNT_MAX);
    // Accept only after the new level has been seen DEBOUNCE_CYCLES edges in a row.
    assign w_accept   = w_mismatch & w_terminal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else begin
            r_s1 <= i_sw_raw;
            r_s2 <= r_s1;
            if (!w_mismatch) begin
                r_cnt <= '0;
            end else if (w_terminal) begin
                r_cnt    <= '0;
                r_stable <= r_s2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_stable = r_stable;

`ifdef SW_EDGE_PULSE_EN
    logic r_rise;
    logic r_fall;

    // Registered on the same edge as r_stable, so each pulse lines up with
    // the first cycle of the new level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_accept & r_s2;
            r_fall <= w_accept & ~r_s2;
        end
    end

    assign o_rise   = r_rise;
    assign o_fall   = r_fall;
    assign o_accept = w_accept;
`endif

endmodule

// File: rtl/sw_debounce_sync.sv
// -----------------------------------------------------------------------------
// sw_debounce_sync
// Synchronises and debounces WIDTH board slide switches independently and
// drives the clean sw_stable bus consumed by the downstream LED stage.
// Optional feature macro: SW_EDGE_PULSE_EN. When undefined, sw_rise, sw_fall
// and sw_changed are tied to 0 and their registers are not built.
// Ports:
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   sw_raw     : raw switch levels [WIDTH]
//   sw_stable  : debounced levels [WIDTH]
//   sw_rise    : per-bit one-cycle pulse on accepted 0->1 [WIDTH]
//   sw_fall    : per-bit one-cycle pulse on accepted 1->0 [WIDTH]
//   sw_changed : OR of sw_rise | sw_fall, registered with them
// -----------------------------------------------------------------------------
module sw_debounce_sync
    import sw_cond_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_100MHZ
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

`ifdef SW_EDGE_PULSE_EN
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_accept;
    logic             r_changed;
`endif

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk      (clk),
            .rst      (rst),
            .i_sw_raw (sw_raw[g]),
            .o_stable (sw_stable[g])
`ifdef SW_EDGE_PULSE_EN
            ,
            .o_rise   (w_rise[g]),
            .o_fall   (w_fall[g]),
            .o_accept (w_accept[g])
`endif
        );
    end

`ifdef SW_EDGE_PULSE_EN
    // Any bit accepting this edge means some pulse is set next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_changed <= 1'b0;
        end else begin
            r_changed <= |w_accept;
        end
    end

    assign sw_rise    = w_rise;
    assign sw_fall    = w_fall;
    assign sw_changed = r_changed;
`else
    assign sw_rise    = '0;
    assign sw_fall    = '0;
    assign sw_changed = 1'b0;
`endif

endmodule

// File: tb/tb_sw_debounce_sync.sv
module tb_sw_debounce_sync;
    import sw_cond_pkg::*;

    localparam int W  = 4;
    localparam int DC = DEBOUNCE_SIM;

    typedef struct packed {
        logic [W-1:0] stable;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         changed;
    } obs_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sw_raw = 4'hF;
    logic [W-1:0] sw_stable;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic         sw_changed;

    int tests = 0;
    int fails = 0;

    obs_t expq[$];

    sw_debounce_sync #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_raw     (sw_raw),
        .sw_stable  (sw_stable),
        .sw_rise    (sw_rise),
        .sw_fall    (sw_fall),
        .sw_changed (sw_changed)
    );

    always #5 clk = ~clk;

    // Reference model: a bit is accepted once its synchronised level (raw
    // delayed by two edges) has disagreed with the accepted level on the
    // last DC edges in a row.
    logic [W-1:0] m_p1 = '0;
    logic [W-1:0] m_p2 = '0;
    logic [W-1:0] m_stable = '0;
    logic         m_hist[W][$];

    always @(posedge clk) begin
        obs_t         e;
        logic [W-1:0] s2;
        int           diff;
        e = '0;
        if (rst) begin
            m_p1 = '0;
            m_p2 = '0;
            m_stable = '0;
            for (int i = 0; i < W; i++) m_hist[i].delete();
        end else begin
            s2   = m_p2;
            m_p2 = m_p1;
            m_p1 = sw_raw;
            for (int i = 0; i < W; i++) begin
                m_hist[i].push_back(s2[i]);
                if (m_hist[i].size() > DC) void'(m_hist[i].pop_front());
                diff = 0;
                foreach (m_hist[i][k]) if (m_hist[i][k] != m_stable[i]) diff++;
                if (diff == DC) begin
                    if (m_stable[i]) e.fall[i] = 1'b1;
                    else             e.rise[i] = 1'b1;
                    m_stable[i] = ~m_stable[i];
                end
            end
            e.stable = m_stable;
`ifndef SW_EDGE_PULSE_EN
            e.rise = '0;
            e.fall = '0;
`endif
            e.changed = |(e.rise | e.fall);
        end
        expq.push_back(e);
    end

    // Monitor: one observation per clock, sampled 1 time unit after the edge.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #1;
            a = '{stable: sw_stable, rise: sw_rise, fall: sw_fall, changed: sw_changed};
            tests++;
            if (expq.size() == 0) begin
                fails++;
                $display("FAIL scoreboard_empty at %0t: no expected entry for actual %h", $time, a);
            end else begin
                e = expq.pop_front();
                if (a !== e)
                    $display("FAIL cycle_check at %0t: actual stable=%h rise=%h fall=%h chg=%b, required stable=%h rise=%h fall=%h chg=%b",
                             $time, a.stable, a.rise, a.fall, a.changed,
                             e.stable, e.rise, e.fall, e.changed);
                if (a !== e) fails++;
            end
        end
    end

    task automatic hold(input logic [W-1:0] v, input int n);
        sw_raw = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_clear(input string name);
        obs_t a;
        a = '{stable: sw_stable, rise: sw_rise, fall: sw_fall, changed: sw_changed};
        tests++;
        if (a !== '0) begin
            fails++;
            $display("FAIL %s: actual %h, required 0", name, a);
        end
    endtask

    initial begin
        // 1: reset with switches high, then release and re-qualify
        repeat (3) @(negedge clk);
        #1 check_clear("reset_hold");
        @(negedge clk);
        rst = 1'b0;
        hold(4'hF, 10);

        // 4: release all switches
        hold(4'h0, 10);

        // 2: clean step to 4'h5
        hold(4'h5, 10);
        hold(4'h0, 10);

        // 3: bounce on bit0, then hold
        for (int k = 0; k < 4; k++) hold((k % 2 == 0) ? 4'h1 : 4'h0, 2);
        hold(4'h1, 10);
        hold(4'h0, 10);

        // 5: reset mid-count on bit2
        hold(4'h4, 4);
        rst = 1'b1;
        #1 check_clear("reset_mid_count");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hold(4'h4, 10);
        hold(4'h0, 10);

        // all bits change together
        hold(4'hF, 10);
        hold(4'hA, 10);

        // randomized bouncing with occasional resets
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                #1 check_clear("reset_random");
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
            if ($urandom_range(0, 7) == 0)
                sw_raw = sw_raw ^ (4'b0001 << $urandom_range(0, 3));
            else if ($urandom_range(0, 49) == 0)
                sw_raw = 4'($urandom_range(0, 15));
            @(negedge clk);
        end

        hold(sw_raw, 12);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
